burst_req_arbiter: RTL
======================

Name: burst_req_arbiter

Overview:
Shares a single valid/a burst channel among NUM_REQ requesters.
- Round-robin arbitration selects one pending requester.
- For the winner it issues a one-cycle `valid` pulse, then holds `a` high for that requester's burst length, clamped to MIN_LEN..MAX_LEN.
- Output protocol satisfies the channel property: rising `valid` implies `a` high for 3 to 6 consecutive cycles starting the next cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 3, width of each requested burst length
MIN_LEN, 3, minimum burst length in cycles
MAX_LEN, 6, maximum burst length in cycles (MIN_LEN <= MAX_LEN < 2**LEN_W)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request; held until its req_ready
req_len  in  NUM_REQ*LEN_W  per-requester burst length; requester i uses slice [i*LEN_W +: LEN_W]
req_ready  out  NUM_REQ  one-hot grant; request accepted when req_valid[i] & req_ready[i]
valid  out  1  burst-start pulse, exactly one cycle per accepted request
a  out  1  burst active
grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current/last burst
busy  out  1  high from the cycle after acceptance until the last `a` cycle inclusive
len_err  out  1  one-cycle pulse coincident with `valid` when req_len was out of range

Behaviour:
Reset
- rst_n sampled low at a posedge forces: state IDLE, valid=0, a=0, busy=0, len_err=0, grant_id=0, counter=0.
- Round-robin pointer reset so requester 0 has highest priority.
- Reset mid-burst aborts the burst immediately (outputs low the next cycle). The aborted request is not retried.

State machine: IDLE, START, BURST.

IDLE
- req_ready is combinational: one-hot of the highest-priority asserted req_valid.
- Priority order is (last_grant+1) mod NUM_REQ upward, wrapping.
- req_ready is all zero outside IDLE and when no req_valid is asserted.
- On acceptance at cycle T:
  - latch grant_id and length L = clamp(req_len, MIN_LEN, MAX_LEN);
  - latch len_err = (req_len < MIN_LEN) | (req_len > MAX_LEN);
  - update pointer to the granted index;
  - go to START.

START (cycle T+1)
- valid=1, busy=1, len_err as latched, a=0.
- Counter loaded with L-1.
- Go to BURST.

BURST (cycles T+2 .. T+1+L)
- a=1, busy=1, valid=0, len_err=0.
- Counter decrements each cycle; at counter==0 go to IDLE.

After the burst
- At cycle T+2+L: a=0, busy=0, and the FSM is in IDLE, able to accept a new request.
- That request's `valid` appears at T+3+L at the earliest, so `valid` always has a low cycle before rising.

Timing and output rules
- Outputs valid, a, busy, len_err and grant_id are registered.
- Latency from acceptance to `valid` is 1 cycle; from acceptance to first `a` is 2 cycles.
- req_valid/req_len changes outside IDLE are ignored. Length is sampled only at acceptance.
- A requester dropping req_valid before acceptance is simply not granted; no error.
- Simultaneous requests are resolved only by the round-robin pointer. A continuously requesting agent waits at most NUM_REQ-1 bursts.
- Burst cycle time is L+2 cycles (START + L + one IDLE).

Test Plan:
- Single request: req_valid[1]=1, req_len=4 at T → req_ready=0010 at T; valid=1 at T+1; a=1 at T+2..T+5; a=0 at T+6; grant_id=1; len_err=0.
- Bounds: req_len=3 → exactly 3 cycles of `a`. req_len=6 → exactly 6 cycles. Checked against assertion `$rose(valid) |=> a[*3:6]` under disable iff(!rst_n).
- Clamp: req_len=0 → 3 cycles of `a`, len_err=1 with valid. req_len=7 → 6 cycles of `a`, len_err=1.
- Round-robin: req_valid=0101 held continuously from reset → grant order 0,2,0,2. Adding req 3 mid-sequence after grant 2 → next grant 3, then 0. Also verify no back-to-back `valid` without an intervening low cycle.
- Reset mid-burst: rst_n=0 on the third `a` cycle → next posedge a=0, valid=0, busy=0, state IDLE, pointer back to 0. After release, req_valid=1111 → grant to 0.
- Ignored inputs: change req_len and drop/raise other req_valid during BURST → burst length unchanged, req_ready stays all zero until IDLE.

Source files
------------

// File: rtl/burst_req_arbiter.sv
// burst_req_arbiter: round-robin share of one valid/a burst channel
// among NUM_REQ requesters, burst length clamped to MIN_LEN..MAX_LEN.
module burst_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 3,
  parameter int MIN_LEN = 3,
  parameter int MAX_LEN = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       valid,
  output logic                       a,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       len_err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BURST
  } state_e;

  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic a_q, a_d;
  logic busy_q, busy_d;
  logic len_err_q, len_err_d;

  logic found;
  logic [IDW-1:0] sel;
  int idx;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] clamp_len;
  logic range_err;

  // Search starts one past the last grant and wraps around.
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_len = req_len[int'(sel)*LEN_W +: LEN_W];
    clamp_len = sel_len;
    range_err = 1'b0;
    if (sel_len < MIN_L) begin
      clamp_len = MIN_L;
      range_err = 1'b1;
    end else if (sel_len > MAX_L) begin
      clamp_len = MAX_L;
      range_err = 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE && found)
                   ? (NUM_REQ'(1) << sel) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_id_d = grant_id_q;
    len_d = len_q;
    cnt_d = cnt_q;
    valid_d = 1'b0;
    a_d = 1'b0;
    busy_d = 1'b0;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = START;
          ptr_d = sel;
          grant_id_d = sel;
          len_d = clamp_len;
          len_err_d = range_err;
          valid_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      START: begin
        state_d = BURST;
        cnt_d = len_q - LEN_W'(1);
        a_d = 1'b1;
        busy_d = 1'b1;
      end
      BURST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          a_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= PTR_RST;
      grant_id_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      a_q <= 1'b0;
      busy_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_id_q <= grant_id_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      a_q <= a_d;
      busy_q <= busy_d;
      len_err_q <= len_err_d;
    end
  end

  assign valid = valid_q;
  assign a = a_q;
  assign busy = busy_q;
  assign len_err = len_err_q;
  assign grant_id = grant_id_q;
endmodule
